apu_shared_unit_arbiter: RTL and testbench
==========================================

Name: apu_shared_unit_arbiter

Overview:
- Shares one fixed-latency pipelined FP unit among NB_CORES cores, e.g. addsub, mult, mac, cast or div.
- Arbitrates requests round-robin and forwards the granted core's operation to the unit.
- Tracks the owner ID of each operation through a shift register matched to the unit's pipeline depth.
- Returns each result only to the core that issued it.
- One instance per shared unit type in the APU cluster. Not instantiated when the matching PRIVATE_FP_* parameter is 1.

Parameters:
- NB_CORES, 4: number of requesting cores (2..16).
- PIPE_REGS, 1: unit latency in cycles (1..8). Set from the C_*_PIPE_REGS constant of the unit type.
- WOP, 1: opcode width.
- NARGS, 3: operand count.
- WIDTH, 32: operand/result width (FP_WIDTH).
- NDSFLAGS, 3: downstream flag width.
- NUSFLAGS, 8: upstream flag width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  NB_CORES  per-core request
- core_gnt_o  out  NB_CORES  per-core grant, one-hot or zero
- core_op_i  in  NB_CORES x WOP  per-core opcode
- core_operands_i  in  NB_CORES x NARGS x WIDTH  per-core operands
- core_flags_i  in  NB_CORES x NDSFLAGS  per-core downstream flags (e.g. rounding mode)
- core_rvalid_o  out  NB_CORES  per-core result valid, one-hot or zero
- core_result_o  out  WIDTH  result, broadcast to all cores
- core_rflags_o  out  NUSFLAGS  result flags, broadcast
- unit_req_o  out  1  operation valid to the unit
- unit_op_o  out  WOP  forwarded opcode
- unit_operands_o  out  NARGS x WIDTH  forwarded operands
- unit_flags_o  out  NDSFLAGS  forwarded flags
- unit_result_i  in  WIDTH  unit result, valid exactly PIPE_REGS cycles after issue
- unit_rflags_i  in  NUSFLAGS  unit result flags
- unit_active_o  out  1  unit busy (request or in-flight op); used by cluster clock gating

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - round-robin pointer = NB_CORES-1, so core 0 has top priority after reset;
  - valid/ID shift register cleared;
  - core_gnt_o = 0, core_rvalid_o = 0, unit_req_o = 0, unit_active_o = 0;
  - unit_op_o, unit_operands_o, unit_flags_o, core_result_o, core_rflags_o = 0.
- Grant:
  - combinational, same cycle as the request;
  - winner = first requesting core at index (ptr+1) mod NB_CORES, ptr+2, ... wrapping;
  - ptr <= winner index on the clock edge after each grant; ptr holds when no core requests;
  - at most one grant per cycle.
- Handshake:
  - a core holds req, op, operands and flags stable until granted;
  - operands are consumed in the grant cycle;
  - the core may drop req, or issue a new op, in the cycle after the grant;
  - back-to-back grants to the same core are allowed only when it is the sole requester.
- Unit side:
  - unit_req_o = |core_req_i;
  - op/operands/flags are muxed from the winner;
  - all unit-side data outputs are 0 when no core is granted;
  - the unit accepts one op every cycle (fully pipelined, no unit-side stall).
- Tracking:
  - PIPE_REGS-deep shift register of {valid, id[$clog2(NB_CORES)-1:0]};
  - stage 0 loads {unit_req_o, winner} each cycle;
  - the tail stage drives core_rvalid_o[id] when valid;
  - each result appears exactly PIPE_REGS cycles after its grant cycle.
- Result data: core_result_o/core_rflags_o pass unit_result_i/unit_rflags_i through combinationally. They are meaningful only when some core_rvalid_o bit is 1.
- No result backpressure: cores must accept rvalid in that cycle.
- unit_active_o = unit_req_o | any valid bit in the shift register.
- Boundaries:
  - all cores requesting continuously: strict rotation 0,1,2,3,0,...;
  - a single requester is granted every cycle;
  - a grant and a result for the same core in one cycle are both honoured;
  - reset asserted mid-flight drops in-flight ops with no rvalid, even if the unit later emits data;
  - a core dropping req before grant is legal (request withdrawn, no side effects).

Optional Feature:
- Macro APU_ARB_PERF_CNT_EN.
- Defined:
  - adds output perf_contention_o, NB_CORES x 16;
  - adds input perf_clr_i, 1;
  - counter[i] increments each cycle core_req_i[i]=1 and core_gnt_o[i]=0;
  - counters saturate at 16'hFFFF;
  - counters are synchronously cleared by perf_clr_i, which has priority over increment;
  - counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- apu_cluster_package adds C_APU_ARB_PERF_CNT_WIDTH = 16 and C_APU_ARB_MAX_CORES = 16.
- Existing WOP_*, NDSFLAGS_*, NUSFLAGS_* and C_*_PIPE_REGS parameters set instance parameters.
- One sub-module, apu_rr_arb: NB_CORES-wide round-robin arbiter (req vector and ptr in, one-hot gnt and winner index out). Purely combinational; the pointer register stays in the parent.

Test Plan (NB_CORES=4, PIPE_REGS=2 unless noted):
- Reset then core 2 alone requests at cycle 5 with operands 3F800000/40000000 → gnt[2]=1 at cycle 5; unit_req_o=1 at cycle 5; rvalid=4'b0100 at cycle 7 with core_result_o = unit_result_i.
- All 4 cores request continuously for 8 cycles after reset → grant order 0,1,2,3,0,1,2,3; rvalid follows the same order delayed by 2; no gaps.
- Cores 1 and 3 request, ptr=1 → core 3 granted first, then core 1 next cycle; each rvalid is routed to its own core.
- rst_ni pulsed low for 1 cycle 1 cycle after a grant to core 0 → no rvalid afterwards; ptr=3; core 0 wins the next contention.
- PIPE_REGS=5, single core requesting every cycle for 10 cycles → 10 rvalids on cycles 5..14 for that core; unit_active_o=1 through cycle 14, then 0 at cycle 15.
- With APU_ARB_PERF_CNT_EN, cores 0 and 1 request for 10 cycles → each counter = 5; perf_clr_i pulse → both counters = 0 on the next cycle.

Source files
------------

// File: rtl/apu_shared_unit_arbiter_pkg.sv
// Shared constants and helpers for the APU shared-unit arbiter.
package apu_shared_unit_arbiter_pkg;

  localparam int unsigned C_APU_ARB_PERF_CNT_WIDTH = 16;
  localparam int unsigned C_APU_ARB_MAX_CORES      = 16;

  // Index of the candidate that is 'offs' positions after 'ptr', wrapping at n.
  function automatic int unsigned rr_next_idx(input int unsigned ptr, input int unsigned offs,
                                              input int unsigned n);
    return (ptr + offs) % n;
  endfunction

endpackage

// File: rtl/apu_rr_arb.sv
// Combinational round-robin arbiter: the search starts one position after ptr_i.
module apu_rr_arb
  import apu_shared_unit_arbiter_pkg::*;
#(
  parameter int unsigned NB_CORES = 4
) (
  input  logic [NB_CORES-1:0]         req_i,
  input  logic [$clog2(NB_CORES)-1:0] ptr_i,
  output logic [NB_CORES-1:0]         gnt_o,
  output logic [$clog2(NB_CORES)-1:0] winner_o,
  output logic                        valid_o
);

  localparam int unsigned IdW = $clog2(NB_CORES);

  int unsigned    idx;
  logic [IdW-1:0] idx_w;

  // First requester found at ptr+1, ptr+2, ... (wrapping) wins.
  always_comb begin
    gnt_o    = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int unsigned i = 1; i <= NB_CORES; i++) begin
      idx   = rr_next_idx(32'(ptr_i), i, NB_CORES);
      idx_w = IdW'(idx);
      if (!valid_o && req_i[idx_w]) begin
        valid_o      = 1'b1;
        gnt_o[idx_w] = 1'b1;
        winner_o     = idx_w;
      end
    end
  end

endmodule

// File: rtl/apu_shared_unit_arbiter.sv
// Shares one fully pipelined fixed-latency FP unit among NB_CORES cores.
// Round-robin grant, owner-ID tracking through a PIPE_REGS-deep shift register,
// result routed back to the issuing core only.
// Optional macro APU_ARB_PERF_CNT_EN adds per-core saturating contention counters.
module apu_shared_unit_arbiter
  import apu_shared_unit_arbiter_pkg::*;
#(
  parameter int unsigned NB_CORES  = 4,
  parameter int unsigned PIPE_REGS = 1,
  parameter int unsigned WOP       = 1,
  parameter int unsigned NARGS     = 3,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NDSFLAGS  = 3,
  parameter int unsigned NUSFLAGS  = 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NB_CORES-1:0]                     core_req_i,
  output logic [NB_CORES-1:0]                     core_gnt_o,
  input  logic [NB_CORES-1:0][WOP-1:0]            core_op_i,
  input  logic [NB_CORES-1:0][NARGS-1:0][WIDTH-1:0] core_operands_i,
  input  logic [NB_CORES-1:0][NDSFLAGS-1:0]       core_flags_i,
  output logic [NB_CORES-1:0]                     core_rvalid_o,
  output logic [WIDTH-1:0]                        core_result_o,
  output logic [NUSFLAGS-1:0]                     core_rflags_o,
  output logic                                    unit_req_o,
  output logic [WOP-1:0]                          unit_op_o,
  output logic [NARGS-1:0][WIDTH-1:0]             unit_operands_o,
  output logic [NDSFLAGS-1:0]                     unit_flags_o,
  input  logic [WIDTH-1:0]                        unit_result_i,
  input  logic [NUSFLAGS-1:0]                     unit_rflags_i,
  output logic                                    unit_active_o
`ifdef APU_ARB_PERF_CNT_EN
  ,
  input  logic                                    perf_clr_i,
  output logic [NB_CORES-1:0][C_APU_ARB_PERF_CNT_WIDTH-1:0] perf_contention_o
`endif
);

  localparam int unsigned IdW = $clog2(NB_CORES);

  logic [IdW-1:0]                ptr_q;
  logic [IdW-1:0]                winner;
  logic [NB_CORES-1:0]           arb_gnt;
  logic                          arb_valid;
  logic                          grant;
  logic [PIPE_REGS-1:0]          vld_q;
  logic [PIPE_REGS-1:0][IdW-1:0] id_q;

  apu_rr_arb #(
    .NB_CORES(NB_CORES)
  ) i_rr_arb (
    .req_i   (core_req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .winner_o(winner),
    .valid_o (arb_valid)
  );

  // Nothing is granted or forwarded while reset is held.
  assign grant      = arb_valid & rst_ni;
  assign core_gnt_o = grant ? arb_gnt : '0;
  assign unit_req_o = grant;

  // Forward the winner's operation; zero data when idle.
  always_comb begin
    unit_op_o       = '0;
    unit_operands_o = '0;
    unit_flags_o    = '0;
    if (grant) begin
      unit_op_o       = core_op_i[winner];
      unit_operands_o = core_operands_i[winner];
      unit_flags_o    = core_flags_i[winner];
    end
  end

  // Pointer follows the last winner; reset value makes core 0 top priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IdW'(NB_CORES - 1);
    end else if (grant) begin
      ptr_q <= winner;
    end
  end

  // Owner tracking pipeline, depth matched to the unit latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= grant;
      id_q[0]  <= winner;
      for (int unsigned s = 1; s < PIPE_REGS; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
      end
    end
  end

  // Tail stage steers the result valid to its owner.
  always_comb begin
    core_rvalid_o = '0;
    if (vld_q[PIPE_REGS-1]) begin
      core_rvalid_o[id_q[PIPE_REGS-1]] = 1'b1;
    end
  end

  assign core_result_o = rst_ni ? unit_result_i : '0;
  assign core_rflags_o = rst_ni ? unit_rflags_i : '0;
  assign unit_active_o = unit_req_o | (|vld_q);

`ifdef APU_ARB_PERF_CNT_EN
  logic [NB_CORES-1:0][C_APU_ARB_PERF_CNT_WIDTH-1:0] perf_q;

  // Count cycles a core waits; clear wins over increment, counters saturate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (perf_clr_i) begin
      perf_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NB_CORES; c++) begin
        if (core_req_i[c] && !core_gnt_o[c] && (perf_q[c] != '1)) begin
          perf_q[c] <= perf_q[c] + C_APU_ARB_PERF_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign perf_contention_o = perf_q;
`endif

endmodule

// File: tb/tb_apu_shared_unit_arbiter.sv
// Directed bench: NB_CORES=4 with PIPE_REGS=2 (main DUT) and PIPE_REGS=5 (latency DUT).
module tb_apu_shared_unit_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  // Main DUT signals
  logic [3:0]             req, gnt, rvalid;
  logic [3:0][0:0]        op;
  logic [3:0][2:0][31:0]  opnds;
  logic [3:0][2:0]        flags;
  logic [31:0]            result;
  logic [7:0]             rflags;
  logic                   ureq, uactive;
  logic [0:0]             uop;
  logic [2:0][31:0]       uopnds;
  logic [2:0]             uflags;
  logic [31:0]            ures;
  logic [7:0]             urflags;

  // PIPE_REGS=5 DUT signals
  logic [3:0]             req5, gnt5, rvalid5;
  logic [31:0]            result5;
  logic [7:0]             rflags5;
  logic                   ureq5, uactive5;
  logic [0:0]             uop5;
  logic [2:0][31:0]       uopnds5;
  logic [2:0]             uflags5;

`ifdef APU_ARB_PERF_CNT_EN
  logic                   perf_clr;
  logic [3:0][15:0]       perf, perf5;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  initial forever #5 clk = ~clk;

  apu_shared_unit_arbiter #(
    .NB_CORES(4), .PIPE_REGS(2), .WOP(1), .NARGS(3), .WIDTH(32), .NDSFLAGS(3), .NUSFLAGS(8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .core_req_i     (req),
    .core_gnt_o     (gnt),
    .core_op_i      (op),
    .core_operands_i(opnds),
    .core_flags_i   (flags),
    .core_rvalid_o  (rvalid),
    .core_result_o  (result),
    .core_rflags_o  (rflags),
    .unit_req_o     (ureq),
    .unit_op_o      (uop),
    .unit_operands_o(uopnds),
    .unit_flags_o   (uflags),
    .unit_result_i  (ures),
    .unit_rflags_i  (urflags),
    .unit_active_o  (uactive)
`ifdef APU_ARB_PERF_CNT_EN
    ,
    .perf_clr_i       (perf_clr),
    .perf_contention_o(perf)
`endif
  );

  apu_shared_unit_arbiter #(
    .NB_CORES(4), .PIPE_REGS(5), .WOP(1), .NARGS(3), .WIDTH(32), .NDSFLAGS(3), .NUSFLAGS(8)
  ) dut5 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .core_req_i     (req5),
    .core_gnt_o     (gnt5),
    .core_op_i      (op),
    .core_operands_i(opnds),
    .core_flags_i   (flags),
    .core_rvalid_o  (rvalid5),
    .core_result_o  (result5),
    .core_rflags_o  (rflags5),
    .unit_req_o     (ureq5),
    .unit_op_o      (uop5),
    .unit_operands_o(uopnds5),
    .unit_flags_o   (uflags5),
    .unit_result_i  (32'h0),
    .unit_rflags_i  (8'h0),
    .unit_active_o  (uactive5)
`ifdef APU_ARB_PERF_CNT_EN
    ,
    .perf_clr_i       (1'b0),
    .perf_contention_o(perf5)
`endif
  );

  // Two-stage unit model: result = operand0 + operand1, rflags = zero-extended flags.
  logic [31:0] sum_p0, sum_p1;
  logic [7:0]  fl_p0, fl_p1;
  always_ff @(posedge clk) begin
    sum_p0 <= uopnds[0] + uopnds[1];
    sum_p1 <= sum_p0;
    fl_p0  <= {5'b0, uflags};
    fl_p1  <= fl_p0;
  end
  assign ures    = sum_p1;
  assign urflags = fl_p1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req   = '0;
    req5  = '0;
    op    = '0;
    opnds = '0;
    flags = '0;
`ifdef APU_ARB_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    rst_n = 1'b0;

    // Reset: outputs quiet even with a request present
    repeat (2) tick();
    req = 4'b0001;
    opnds[0][0] = 32'h1234;
    #1;
    check("rst_gnt",    gnt,       0);
    check("rst_ureq",   ureq,      0);
    check("rst_rvalid", rvalid,    0);
    check("rst_active", uactive,   0);
    check("rst_uopnd",  uopnds[0], 0);
    check("rst_result", result,    0);
    req = '0;
    opnds = '0;
    tick();
    rst_n = 1'b1;

    // Core 2 alone at cycle 5
    repeat (4) tick();
    req = 4'b0100;
    op[2] = 1'b1;
    opnds[2][0] = 32'h3F800000;
    opnds[2][1] = 32'h40000000;
    flags[2] = 3'b101;
    #1;
    check("t1_gnt",    gnt,       4'b0100);
    check("t1_ureq",   ureq,      1);
    check("t1_uop",    uop,       1);
    check("t1_uopnd0", uopnds[0], 32'h3F800000);
    check("t1_uopnd1", uopnds[1], 32'h40000000);
    check("t1_uflags", uflags,    3'b101);
    tick();
    req = '0;
    #1;
    check("t1_gnt_idle",  gnt,       0);
    check("t1_rvalid_c6", rvalid,    0);
    check("t1_uopnd_0",   uopnds[0], 0);
    check("t1_active_c6", uactive,   1);
    tick();
    #1;
    check("t1_rvalid", rvalid, 4'b0100);
    check("t1_result", result, 32'h7F800000);
    check("t1_rflags", rflags, 8'h05);
    tick();
    #1;
    check("t1_rvalid_after", rvalid,  0);
    check("t1_active_after", uactive, 0);

    // Full contention after reset: strict rotation 0,1,2,3
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      opnds[k][0] = 32'(k + 1);
      opnds[k][1] = 32'h100;
      flags[k] = 3'(k);
    end
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) req = '0;
      #1;
      check("rot_gnt", gnt, (i < 8) ? (4'b0001 << (i % 4)) : 4'b0000);
      if (i >= 2) begin
        check("rot_rvalid", rvalid, 4'b0001 << ((i - 2) % 4));
        check("rot_result", result, 32'h101 + 32'((i - 2) % 4));
      end
      tick();
    end

    // ptr=1, cores 1 and 3 contend: 3 then 1; each result goes to its owner
    req = 4'b0010;
    #1;
    check("t3_setup_gnt", gnt, 4'b0010);
    tick();
    req = 4'b1010;
    #1;
    check("t3_gnt_a", gnt, 4'b1000);
    tick();
    req = 4'b0010;
    #1;
    check("t3_gnt_b",    gnt,    4'b0010);
    check("t3_rvalid_a", rvalid, 4'b0010);
    check("t3_result_a", result, 32'h102);
    tick();
    req = '0;
    #1;
    check("t3_rvalid_b", rvalid, 4'b1000);
    check("t3_result_b", result, 32'h104);
    tick();
    #1;
    check("t3_rvalid_c", rvalid, 4'b0010);
    check("t3_result_c", result, 32'h102);
    tick();

    // Reset mid-flight drops the op; ptr returns to 3
    req = 4'b0001;
    #1;
    check("t4_gnt", gnt, 4'b0001);
    tick();
    req = '0;
    rst_n = 1'b0;
    #1;
    check("t4_rvalid_rst", rvalid,  0);
    check("t4_active_rst", uactive, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t4_rvalid_drop", rvalid, 0);
    tick();
    check("t4_rvalid_drop2", rvalid, 0);
    req = 4'b1111;
    #1;
    check("t4_ptr_gnt", gnt, 4'b0001);
    tick();
    req = '0;
    repeat (3) tick();

    // PIPE_REGS=5, core 1 requests 10 cycles
    for (int i = 0; i < 17; i++) begin
      req5 = (i < 10) ? 4'b0010 : 4'b0000;
      #1;
      check("p5_gnt",    gnt5,     (i < 10) ? 4'b0010 : 4'b0000);
      check("p5_rvalid", rvalid5,  (i >= 5 && i <= 14) ? 4'b0010 : 4'b0000);
      check("p5_active", uactive5, (i <= 14) ? 1 : 0);
      tick();
    end

`ifdef APU_ARB_PERF_CNT_EN
    // Two-way contention for 10 cycles: each core waits 5 of them
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    req = 4'b0011;
    repeat (10) tick();
    req = '0;
    #1;
    check("perf_c0", perf[0], 16'd5);
    check("perf_c1", perf[1], 16'd5);
    check("perf_c2", perf[2], 16'd0);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    #1;
    check("perf_clr_c0", perf[0], 16'd0);
    check("perf_clr_c1", perf[1], 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
